// File: rtl/scan_ctrl_pkg.sv
// Shared types and helpers for the scan-chain shadow control register.
package scan_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFTING,
        FULL,
        OVER
    } state_t;

    // Counter must hold 0..N+1 so an overshift stays distinguishable from a full frame
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/scan_edge_det.sv
// Synchronous rising-edge detector with synchronous active-low reset.
module scan_edge_det (
    input  logic clk,
    input  logic resetb,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/scan_ctrl_shadow_reg.sv
// Serial scan chain feeding a framed shadow control register (NCH x WIDTH bits).
// Optional readback of the shadow value into the chain is enabled by READBACK_EN.
module scan_ctrl_shadow_reg
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned              WIDTH     = DEF_WIDTH,
    parameter int unsigned              NCH       = 3,
    parameter logic [WIDTH*NCH-1:0]     RESET_VAL = '0
) (
    input  logic                 SCAN_CLK,
    input  logic                 RESETB,
    input  logic                 SCAN_EN,
    input  logic                 SCAN_IN,
    input  logic                 LOAD,
    input  logic                 CAPTURE,
    output logic                 SCAN_OUT,
    output logic [WIDTH*NCH-1:0] CTRL,
    output logic                 LOAD_DONE,
    output logic                 LOAD_ERR,
    output logic                 BUSY
);

    localparam int unsigned N  = WIDTH * NCH;
    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_N   = CW'(N);
    localparam logic [CW-1:0] CNT_MAX = CW'(N + 1);

    logic [N-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    state_t        state;
    state_t        state_inc;
    logic          load_rise;
    logic          capture_ok;

    scan_edge_det u_load_edge (
        .clk    (SCAN_CLK),
        .resetb (RESETB),
        .d      (LOAD),
        .rise   (load_rise)
    );

`ifdef READBACK_EN
    assign capture_ok = CAPTURE && (state == IDLE);
`else
    assign capture_ok = CAPTURE & 1'b0;
`endif

    always_comb begin
        cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        state_inc = SHIFTING;
        if (cnt_inc == CNT_N) begin
            state_inc = FULL;
        end else if (cnt_inc > CNT_N) begin
            state_inc = OVER;
        end
    end

    // Load edge outranks both shift and capture; the chain itself is never touched by a commit
    always_ff @(posedge SCAN_CLK) begin
        if (!RESETB) begin
            shreg     <= '0;
            cnt       <= '0;
            state     <= IDLE;
            CTRL      <= RESET_VAL;
            LOAD_DONE <= 1'b0;
            LOAD_ERR  <= 1'b0;
        end else begin
            LOAD_DONE <= 1'b0;
            LOAD_ERR  <= 1'b0;
            if (load_rise) begin
                if (state == FULL) begin
                    CTRL      <= shreg;
                    LOAD_DONE <= 1'b1;
                end else begin
                    LOAD_ERR  <= 1'b1;
                end
                cnt   <= '0;
                state <= IDLE;
            end else if (capture_ok) begin
                shreg <= CTRL;
            end else if (SCAN_EN) begin
                shreg <= {shreg[N-2:0], SCAN_IN};
                cnt   <= cnt_inc;
                state <= state_inc;
            end
        end
    end

    assign SCAN_OUT = shreg[N-1];
    assign BUSY     = (state != IDLE);

endmodule

// File: tb/tb_scan_ctrl_shadow_reg.sv
// Directed self-checking bench for scan_ctrl_shadow_reg (WIDTH=5, NCH=3, N=15).
module tb_scan_ctrl_shadow_reg;

    logic        clk = 1'b0;
    logic        resetb;
    logic        scan_en;
    logic        scan_in;
    logic        load;
    logic        capture;
    logic        scan_out;
    logic [14:0] ctrl;
    logic        load_done;
    logic        load_err;
    logic        busy;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    scan_ctrl_shadow_reg #(
        .WIDTH     (5),
        .NCH       (3),
        .RESET_VAL (15'h0000)
    ) dut (
        .SCAN_CLK  (clk),
        .RESETB    (resetb),
        .SCAN_EN   (scan_en),
        .SCAN_IN   (scan_in),
        .LOAD      (load),
        .CAPTURE   (capture),
        .SCAN_OUT  (scan_out),
        .CTRL      (ctrl),
        .LOAD_DONE (load_done),
        .LOAD_ERR  (load_err),
        .BUSY      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic shift_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            scan_en = 1'b1;
            scan_in = val[i];
            tick();
        end
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    logic [14:0] old_sh;
    logic [14:0] stream_exp;
    int          done_cnt;

    initial begin
        resetb  = 1'b0;
        scan_en = 1'b1;
        scan_in = 1'b1;
        load    = 1'b1;
        capture = 1'b0;
        tick();
        tick();
        check("rst_ctrl", 32'(ctrl), 32'h0);
        check("rst_scan_out", 32'(scan_out), 32'h0);
        check("rst_done", 32'(load_done), 32'h0);
        check("rst_err", 32'(load_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        resetb  = 1'b1;
        scan_en = 1'b0;
        scan_in = 1'b0;
        load    = 1'b0;
        tick();
        check("idle_after_rst", 32'({load_done, load_err, busy}), 32'h0);

        // nominal frame
        shift_bits(32'h5A3C, 15);
        check("full_busy", 32'(busy), 32'h1);
        check("full_ctrl_held", 32'(ctrl), 32'h0);
        load = 1'b1;
        tick();
        check("nom_ctrl", 32'(ctrl), 32'h5A3C);
        check("nom_ch2", 32'(ctrl[14:10]), 32'h16);
        check("nom_done", 32'(load_done), 32'h1);
        check("nom_err", 32'(load_err), 32'h0);
        check("nom_busy", 32'(busy), 32'h0);
        load = 1'b0;
        tick();
        check("nom_done_off", 32'(load_done), 32'h0);

        // undershift
        shift_bits(32'h1234, 14);
        check("under_busy", 32'(busy), 32'h1);
        load = 1'b1;
        tick();
        check("under_ctrl", 32'(ctrl), 32'h5A3C);
        check("under_err", 32'(load_err), 32'h1);
        check("under_done", 32'(load_done), 32'h0);
        load = 1'b0;
        tick();
        check("under_err_off", 32'(load_err), 32'h0);

        // overshift
        shift_bits(32'h1FFFF, 17);
        load = 1'b1;
        tick();
        check("over_ctrl", 32'(ctrl), 32'h5A3C);
        check("over_err", 32'(load_err), 32'h1);
        check("over_done", 32'(load_done), 32'h0);
        load = 1'b0;
        tick();

        // LOAD held high: single commit
        shift_bits(32'h1357, 15);
        load     = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (load_done) done_cnt++;
        end
        check("held_done_count", 32'(done_cnt), 32'd1);
        check("held_ctrl", 32'(ctrl), 32'h1357);
        shift_bits(32'h2468, 15);
        check("held_no_recommit", 32'(ctrl), 32'h1357);
        check("held_full_busy", 32'(busy), 32'h1);
        load = 1'b0;
        tick();
        load = 1'b1;
        tick();
        check("retoggle_ctrl", 32'(ctrl), 32'h2468);
        check("retoggle_done", 32'(load_done), 32'h1);
        load = 1'b0;
        tick();

        // shift and load edge in the same cycle: load wins
        shift_bits(32'h4F0F, 15);
        load    = 1'b1;
        scan_en = 1'b1;
        scan_in = 1'b1;
        tick();
        check("sim_ctrl", 32'(ctrl), 32'h4F0F);
        check("sim_done", 32'(load_done), 32'h1);
        check("sim_no_shift", 32'(scan_out), 32'h1);
        check("sim_idle", 32'(busy), 32'h0);
        load    = 1'b0;
        scan_en = 1'b0;
        scan_in = 1'b0;
        tick();

        // readback
        shift_bits(32'h7001, 15);
        load = 1'b1;
        tick();
        check("rb_commit", 32'(ctrl), 32'h7001);
        load = 1'b0;
        tick();
        shift_bits(32'h5, 3);
        old_sh = 15'h7001;
        old_sh = {old_sh[11:0], 3'b101};
        load = 1'b1;
        tick();
        check("rb_err", 32'(load_err), 32'h1);
        load = 1'b0;
        tick();
        capture = 1'b1;
        tick();
        capture = 1'b0;
        check("rb_capture_idle", 32'(busy), 32'h0);
`ifdef READBACK_EN
        stream_exp = 15'h7001;
`else
        stream_exp = old_sh;
`endif
        for (int i = 14; i >= 0; i--) begin
            check($sformatf("rb_stream_%0d", 14 - i), 32'(scan_out), 32'(stream_exp[i]));
            scan_en = 1'b1;
            tick();
        end
        scan_en = 1'b0;
        check("rb_ctrl_kept", 32'(ctrl), 32'h7001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
